// File: rtl/kamus_pkg.sv
// Shared types and constants for the kamus IF/ID instruction queue.
// Optional fall-through path is enabled by defining KAMUS_IBUF_BYPASS_EN.
package kamus_pkg;

   localparam logic [31:0] KAMUS_NOP = 32'h0000_0013;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
      logic [31:0] next_pc;
   } ibuf_entry_t;

   // Value presented to ID whenever no entry is valid.
   function automatic ibuf_entry_t ibuf_nop_entry();
      ibuf_entry_t e;
      e.instr   = KAMUS_NOP;
      e.pc      = 32'h0000_0000;
      e.next_pc = 32'h0000_0000;
      return e;
   endfunction

endpackage

// File: rtl/kamus_sync_fifo.sv
// Generic synchronous FIFO: wrapping pointers, separate occupancy count,
// synchronous clear and an un-reset storage array.
module kamus_sync_fifo #(
   parameter type         T     = logic [95:0],
   parameter int unsigned DEPTH = 2
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic                       clr_i,
   input  logic                       wr_en_i,
   input  T                           wr_data_i,
   input  logic                       rd_en_i,
   output T                           rd_data_o,
   output logic [$clog2(DEPTH+1)-1:0] count_o,
   output logic                       full_o,
   output logic                       empty_o
);
   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   logic [PTR_W-1:0] wr_ptr_r;
   logic [PTR_W-1:0] rd_ptr_r;
   logic [CNT_W-1:0] count_r;
   logic [CNT_W-1:0] count_nxt_s;
   T                 mem_r [DEPTH];

   // Occupancy update from the write/read strobes.
   always_comb begin
      count_nxt_s = count_r;
      case ({wr_en_i, rd_en_i})
         2'b10:   count_nxt_s = count_r + CNT_W'(1);
         2'b01:   count_nxt_s = count_r - CNT_W'(1);
         default: count_nxt_s = count_r;
      endcase
   end

   // Pointer and count registers; clear has priority over traffic.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_r <= {PTR_W{1'b0}};
         rd_ptr_r <= {PTR_W{1'b0}};
         count_r  <= {CNT_W{1'b0}};
      end else if (clr_i) begin
         wr_ptr_r <= {PTR_W{1'b0}};
         rd_ptr_r <= {PTR_W{1'b0}};
         count_r  <= {CNT_W{1'b0}};
      end else begin
         if (wr_en_i) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
         if (rd_en_i) rd_ptr_r <= rd_ptr_r + PTR_W'(1);
         count_r <= count_nxt_s;
      end
   end

   // Storage write port.
   always_ff @(posedge clk_i) begin
      if (wr_en_i && !clr_i) mem_r[wr_ptr_r] <= wr_data_i;
   end

   assign rd_data_o = mem_r[rd_ptr_r];
   assign count_o   = count_r;
   assign full_o    = (count_r == CNT_W'(DEPTH));
   assign empty_o   = (count_r == {CNT_W{1'b0}});

endmodule

// File: rtl/kamus_if_id_buffer.sv
// IF->ID instruction queue with flush masking and NOP forcing on empty.
// Define KAMUS_IBUF_BYPASS_EN for zero-latency fall-through when empty.
module kamus_if_id_buffer
   import kamus_pkg::*;
#(
   parameter int unsigned DEPTH = 2
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic                       flush_i,
   input  logic                       if_valid_i,
   output logic                       if_ready_o,
   input  logic [31:0]                if_instr_i,
   input  logic [31:0]                if_pc_i,
   input  logic [31:0]                if_next_pc_i,
   output logic                       id_valid_o,
   input  logic                       id_ready_i,
   output logic [31:0]                id_instr_o,
   output logic [31:0]                id_pc_o,
   output logic [31:0]                id_next_pc_o,
   output logic [$clog2(DEPTH+1)-1:0] count_o
);
   ibuf_entry_t in_entry_s;
   ibuf_entry_t head_s;
   ibuf_entry_t out_entry_s;
   logic        full_s;
   logic        empty_s;
   logic        enq_s;
   logic        byp_s;
   logic        out_valid_s;
   logic        wr_en_s;
   logic        rd_en_s;

   // Handshake decode, flush masking and optional fall-through selection.
   always_comb begin
      in_entry_s.instr   = if_instr_i;
      in_entry_s.pc      = if_pc_i;
      in_entry_s.next_pc = if_next_pc_i;
      enq_s = if_valid_i & ~full_s & ~flush_i;
`ifdef KAMUS_IBUF_BYPASS_EN
      byp_s = enq_s & empty_s;
`else
      byp_s = 1'b0;
`endif
      out_valid_s = ~flush_i & (~empty_s | byp_s);
      if (byp_s) begin
         out_entry_s = in_entry_s;
      end else begin
         out_entry_s = head_s;
      end
      // A fall-through entry taken by ID the same cycle is never stored.
      wr_en_s = enq_s & ~(byp_s & id_ready_i);
      rd_en_s = out_valid_s & id_ready_i & ~byp_s;
   end

   kamus_sync_fifo #(
      .T     (ibuf_entry_t),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .clr_i     (flush_i),
      .wr_en_i   (wr_en_s),
      .wr_data_i (in_entry_s),
      .rd_en_i   (rd_en_s),
      .rd_data_o (head_s),
      .count_o   (count_o),
      .full_o    (full_s),
      .empty_o   (empty_s)
   );

   // Output drive; invalid slots show a NOP so stale or unknown data never leaks.
   always_comb begin
      ibuf_entry_t sel_s;
      if (out_valid_s) begin
         sel_s = out_entry_s;
      end else begin
         sel_s = ibuf_nop_entry();
      end
      id_valid_o   = out_valid_s;
      id_instr_o   = sel_s.instr;
      id_pc_o      = sel_s.pc;
      id_next_pc_o = sel_s.next_pc;
   end

   assign if_ready_o = ~full_s;

endmodule

// File: tb/tb_kamus_if_id_buffer.sv
// Scoreboard bench for kamus_if_id_buffer: directed scenarios plus random traffic
// checked against a queue-level reference model.
module tb_kamus_if_id_buffer;
   import kamus_pkg::*;

   localparam int unsigned DEPTH = 2;

   logic        clk = 1'b0;
   logic        rst_ni = 1'b0;
   logic        flush_i = 1'b0;
   logic        if_valid_i = 1'b0;
   logic        if_ready_o;
   logic [31:0] if_instr_i = 32'h0;
   logic [31:0] if_pc_i = 32'h0;
   logic [31:0] if_next_pc_i = 32'h0;
   logic        id_valid_o;
   logic        id_ready_i = 1'b0;
   logic [31:0] id_instr_o;
   logic [31:0] id_pc_o;
   logic [31:0] id_next_pc_o;
   logic [1:0]  count_o;

   kamus_if_id_buffer #(.DEPTH(DEPTH)) dut (
      .clk_i        (clk),
      .rst_ni       (rst_ni),
      .flush_i      (flush_i),
      .if_valid_i   (if_valid_i),
      .if_ready_o   (if_ready_o),
      .if_instr_i   (if_instr_i),
      .if_pc_i      (if_pc_i),
      .if_next_pc_i (if_next_pc_i),
      .id_valid_o   (id_valid_o),
      .id_ready_i   (id_ready_i),
      .id_instr_o   (id_instr_o),
      .id_pc_o      (id_pc_o),
      .id_next_pc_o (id_next_pc_o),
      .count_o      (count_o)
   );

   always #5 clk = ~clk;

   int          n_cmp = 0;
   int          n_err = 0;
   ibuf_entry_t exp_q[$];
   logic        mon_en = 1'b0;
   logic        ready_exp = 1'b1;
   logic        byp_taken = 1'b0;
   logic        take_new = 1'b1;
   logic [31:0] cur_instr = 32'h0;
   logic [31:0] cur_pc = 32'h0;
   logic [31:0] pc_ctr = 32'h0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Drive one cycle of stimulus on the falling edge; an unaccepted entry is held.
   task automatic step(input logic v, input logic r, input logic f);
      @(negedge clk);
      if_valid_i = v;
      id_ready_i = r;
      flush_i    = f;
      if (v) begin
         if (take_new) begin
            cur_instr = $urandom;
            cur_pc    = pc_ctr;
            pc_ctr    = pc_ctr + 32'd4;
            take_new  = 1'b0;
         end
         if_instr_i   = cur_instr;
         if_pc_i      = cur_pc;
         if_next_pc_i = cur_pc + 32'd4;
      end else begin
         if_instr_i   = 'x;
         if_pc_i      = 'x;
         if_next_pc_i = 'x;
      end
   endtask

   // Monitor: compare outputs against the model and pop on every consumed entry.
   initial begin
      int          sz;
      logic        exp_v;
      ibuf_entry_t e;
      forever begin
         @(negedge clk);
         #3;
         if (mon_en) begin
            sz    = exp_q.size();
            exp_v = !flush_i && (sz > 0);
`ifdef KAMUS_IBUF_BYPASS_EN
            if (!flush_i && sz == 0 && if_valid_i) exp_v = 1'b1;
`endif
            chk("count", 32'(count_o), 32'(sz));
            chk("if_ready", 32'(if_ready_o), 32'(sz < DEPTH));
            chk("id_valid", 32'(id_valid_o), 32'(exp_v));
            ready_exp = (sz < DEPTH);
            byp_taken = 1'b0;
            if (exp_v) begin
               if (sz > 0) begin
                  e = exp_q[0];
               end else begin
                  e.instr   = if_instr_i;
                  e.pc      = if_pc_i;
                  e.next_pc = if_next_pc_i;
               end
               chk("id_instr", id_instr_o, e.instr);
               chk("id_pc", id_pc_o, e.pc);
               chk("id_next_pc", id_next_pc_o, e.next_pc);
               if (id_ready_i) begin
                  if (sz > 0) void'(exp_q.pop_front());
                  else byp_taken = 1'b1;
               end
            end else begin
               chk("nop_instr", id_instr_o, KAMUS_NOP);
               chk("nop_pc", id_pc_o, 32'h0);
               chk("nop_next_pc", id_next_pc_o, 32'h0);
            end
         end
      end
   end

   // Reference model: at each edge a flush empties the queue, else an accepted entry joins it.
   initial begin
      ibuf_entry_t e;
      forever begin
         @(posedge clk);
         if (mon_en) begin
            if (flush_i) begin
               exp_q.delete();
               if (if_valid_i) take_new <= 1'b1;
            end else if (if_valid_i && ready_exp) begin
               e.instr   = if_instr_i;
               e.pc      = if_pc_i;
               e.next_pc = if_next_pc_i;
               if (!byp_taken) exp_q.push_back(e);
               take_new <= 1'b1;
            end
         end
      end
   end

   initial begin
      @(negedge clk);
      rst_ni = 1'b1;
      mon_en = 1'b1;
      step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);

      // Fill to full with ID stalled, hold the third entry, then drain in order.
      repeat (4) step(1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b0);
      repeat (3) step(1'b0, 1'b1, 1'b0);

      // Streaming at occupancy one.
      step(1'b1, 1'b0, 1'b0);
      repeat (8) step(1'b1, 1'b1, 1'b0);
      repeat (2) step(1'b0, 1'b1, 1'b0);

      // Flush a full queue while IF offers another entry.
      repeat (2) step(1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b1);
      step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b0);

      // Asynchronous reset between edges with one entry held.
      step(1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      @(posedge clk);
      mon_en = 1'b0;
      #2;
      rst_ni = 1'b0;
      #1;
      chk("rst_valid", 32'(id_valid_o), 32'h0);
      chk("rst_count", 32'(count_o), 32'h0);
      chk("rst_ready", 32'(if_ready_o), 32'h1);
      chk("rst_instr", id_instr_o, KAMUS_NOP);
      chk("rst_pc", id_pc_o, 32'h0);
      exp_q.delete();
      @(negedge clk);
      if_valid_i = 1'b0;
      rst_ni     = 1'b1;
      mon_en     = 1'b1;
      step(1'b0, 1'b1, 1'b0);

`ifdef KAMUS_IBUF_BYPASS_EN
      // Fall-through on empty queue: consumed the same cycle, never stored.
      step(1'b1, 1'b1, 1'b0);
      if_instr_i = 32'h0050_0093;
      #2;
      chk("byp_valid", 32'(id_valid_o), 32'h1);
      chk("byp_instr", id_instr_o, 32'h0050_0093);
      step(1'b0, 1'b0, 1'b0);
      chk("byp_count", 32'(count_o), 32'h0);
`endif

      // Random traffic with occasional flushes.
      for (int i = 0; i < 400; i++) begin
         step(($urandom % 4) != 0, ($urandom % 3) != 0, ($urandom % 20) == 0);
      end
      repeat (4) step(1'b0, 1'b1, 1'b0);
      @(negedge clk);
      #4;
      mon_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
